iq_credit_arbiter: RTL and testbench
====================================

# iq_credit_arbiter

Credit-based front-end arbiter that shares one issue queue among N requesters. It owns the queue's credit pool and grants at most one requester per cycle in round-robin order, only while a credit is held. The winner's payload is registered onto the queue's put/din port. The block sits directly in front of the issue queue and consumes the queue's per-entry credit returns and its replenish pulse.

## Interface
- N, 4, number of requesters (2..8)
- DW, 16, payload width
- DEPTH, 8, issue-queue entries, which is also the maximum credit count
- CW, $clog2(DEPTH+1), credit counter width (derived; do not override)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- replenish  in  1  one-cycle pulse from the queue; the queue is empty and ready for DEPTH entries
- flush  in  1  one-cycle pulse; stop granting until the next replenish
- credit_ret  in  1  the queue freed one entry this cycle
- src_req  in  N  request per requester; bit i belongs to requester i
- src_data  in  N*DW  payloads; requester i occupies bits [i*DW +: DW]
- src_gnt  out  N  combinational one-hot grant; requester i's data is consumed in the cycle src_gnt[i]=1
- put  out  1  registered write strobe to the queue
- din  out  DW  registered payload to the queue
- credits  out  CW  current credit count (register)
- busy  out  1  1 in RUN and credits==0, or in INIT/DRAIN while any src_req is set
- err  out  1  sticky credit-overflow flag, cleared only by rst

## Operation
- FSM states:
  - INIT (reset state): grants blocked.
  - RUN: grants enabled.
  - DRAIN: grants blocked.
- FSM transitions:
  - INIT→RUN on replenish.
  - RUN→DRAIN on flush.
  - DRAIN→RUN on replenish.
  - replenish in RUN stays in RUN and reloads credits.
  - If flush and replenish arrive in the same cycle, replenish wins: state goes to RUN and credits=DEPTH.
- Grant condition: state==RUN, credits!=0, no replenish or flush this cycle, and |src_req.
- Round-robin:
  - Pointer ptr (0..N-1), reset 0.
  - Search order is ptr, ptr+1, … mod N; the first set src_req bit wins.
  - After a grant to i, ptr←(i+1) mod N. With no grant, ptr holds.
- Credit update, evaluated in priority order:
  - replenish: credits←DEPTH, and credit_ret is ignored.
  - Otherwise: credits←credits − g + credit_ret, where g = grant issued this cycle.
  - credit_ret with credits==DEPTH and g=0: credits hold at DEPTH and err←1.
- Credits are not modified by flush. credit_ret in INIT or DRAIN is still counted, including the overflow check.
- Output register:
  - put←g.
  - din←granted requester's data when g=1; otherwise din holds its previous value.

## Timing
- Reset values: state=INIT, credits=0, ptr=0, put=0, din=0, err=0. src_gnt=0 because the grant is blocked in INIT.
- Grant to queue latency: src_gnt at cycle t, then put=1 and din=data at cycle t+1. At most one put per cycle.
- Back-to-back grants every cycle while credits last. Single-requester throughput is 1 per cycle.
- credit_ret at cycle t is visible in credits at t+1 and enables a grant at t+1, not at t.
- Grant with simultaneous credit_ret leaves credits unchanged. A grant at credits==1 with credit_ret keeps credits=1.
- replenish or flush at cycle t suppresses src_gnt at t. The first grant after replenish is at t+1.
- rst mid-operation:
  - All state returns to reset values at the next edge.
  - Any put in flight is dropped (put=0 after the reset edge).
  - No grant until a new replenish.
- Requesters must hold src_req and src_data until they see src_gnt. src_req may be dropped without a grant.

## Test plan
- **Reset and replenish:** assert rst 2 cycles with src_req=4'b1111 → src_gnt=0, credits=0, put=0. Pulse replenish → credits=8 next cycle, first grant to requester 0 the cycle after replenish.
- **Round-robin fairness:** replenish, then all 4 requesting continuously with DEPTH=8 and no credit_ret → grants 0,1,2,3,0,1,2,3 on 8 consecutive cycles. credits=0, then busy=1, src_gnt=0. din sequence matches the src_data of the winners, one cycle later.
- **Steady state:** credits=0, src_req=4'b0100, credit_ret pulsed every cycle → first grant the cycle after the first credit_ret. Grants every cycle thereafter and credits stays 0→1→1….
- **Overflow:** replenish (credits=8), no grants, credit_ret=1 → credits stays 8, err=1 next cycle and remains 1 until rst.
- **Flush/replenish mid-stream:**
  - Granting in RUN with credits=5, pulse flush → no src_gnt that cycle or after. credits stays 5 plus any credit_ret; state DRAIN.
  - Pulse replenish → credits=8 and grants resume the next cycle from the saved ptr.
  - Simultaneous flush+replenish → RUN with credits=8.
- **Reset mid-operation:** at credits=3 with put=1 in flight, assert rst → next cycle put=0, credits=0, ptr=0, err=0. No grant until the next replenish.

Source files
------------

// File: rtl/iq_credit_arbiter.sv
// iq_credit_arbiter: round-robin front-end arbiter for one issue queue.
// Owns the queue's credit pool, grants at most one requester per cycle
// while a credit is held, and registers the winner's payload onto put/din.
//
// Handshake: a requester holds src_req[i] and its src_data slice stable until
// it observes src_gnt[i]=1. The payload is consumed in that same cycle.
// The queue side has no back-pressure: credits guarantee room, so put is a
// plain one-cycle write strobe with din valid alongside it.
module iq_credit_arbiter #(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int PW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            replenish,
    input  logic            flush,
    input  logic            credit_ret,
    input  logic [N-1:0]    src_req,
    input  logic [N*DW-1:0] src_data,
    output logic [N-1:0]    src_gnt,
    output logic            put,
    output logic [DW-1:0]   din,
    output logic [CW-1:0]   credits,
    output logic            busy,
    output logic            err,
    output logic [1:0]      dbg_state,
    output logic [PW-1:0]   dbg_ptr
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t          state_q, state_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            put_q;
    logic [DW-1:0]   din_q, din_d;
    logic            err_q, err_d;

    logic            found;
    logic [PW-1:0]   gnt_idx;
    logic            g;

    // Round-robin search starting at ptr_q; first set request wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (int'(ptr_q) + k) % N;
            if (!found && src_req[PW'(c)]) begin
                found   = 1'b1;
                gnt_idx = PW'(c);
            end
        end
    end

    // Grant qualification, grant vector and busy indication.
    always_comb begin
        g = (state_q == S_RUN) && (credits_q != '0) && !replenish && !flush
            && !rst && found;
        src_gnt = '0;
        if (g) begin
            src_gnt = {{(N-1){1'b0}}, 1'b1} << gnt_idx;
        end
        busy = ((state_q == S_RUN) && (credits_q == '0))
            || ((state_q != S_RUN) && (|src_req));
    end

    // Next-state: replenish always lands in RUN; flush only leaves RUN.
    always_comb begin
        state_d = state_q;
        if (replenish) begin
            state_d = S_RUN;
        end else if (flush && (state_q == S_RUN)) begin
            state_d = S_DRAIN;
        end
    end

    // Credit accounting, overflow detection, pointer and payload capture.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        ptr_d     = ptr_q;
        din_d     = din_q;
        if (replenish) begin
            credits_d = FULL;
        end else if (g && !credit_ret) begin
            credits_d = credits_q - 1'b1;
        end else if (!g && credit_ret) begin
            if (credits_q == FULL) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
        if (g) begin
            ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            din_d = src_data[gnt_idx*DW +: DW];
        end
    end

    // State, credit, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            credits_q <= '0;
            ptr_q     <= '0;
            put_q     <= 1'b0;
            din_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            ptr_q     <= ptr_d;
            put_q     <= g;
            din_q     <= din_d;
            err_q     <= err_d;
        end
    end

    assign put       = put_q;
    assign din       = din_q;
    assign credits   = credits_q;
    assign err       = err_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_iq_credit_arbiter.sv
// Directed bench for iq_credit_arbiter (N=4, DW=16, DEPTH=8).
module tb_iq_credit_arbiter;

  localparam int N = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          replenish;
  logic          flush;
  logic          credit_ret;
  logic [N-1:0]  src_req;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]  src_gnt;
  logic          put;
  logic [DW-1:0] din;
  logic [3:0]    credits;
  logic          busy;
  logic          err;
  logic [1:0]    dbg_state;
  logic [1:0]    dbg_ptr;

  int n_tests = 0;
  int n_fail = 0;

  logic [DW-1:0] dat [N];

  iq_credit_arbiter #(.N(N), .DW(DW), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .replenish(replenish), .flush(flush),
    .credit_ret(credit_ret), .src_req(src_req), .src_data(src_data),
    .src_gnt(src_gnt), .put(put), .din(din), .credits(credits),
    .busy(busy), .err(err), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; land 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    dat[0] = 16'h1111; dat[1] = 16'h2222; dat[2] = 16'h3333; dat[3] = 16'h4444;
    src_data = {dat[3], dat[2], dat[1], dat[0]};
    rst = 1'b1; replenish = 1'b0; flush = 1'b0; credit_ret = 1'b0;
    src_req = 4'b1111;

    // Reset: 2 cycles with all requesting
    step();
    step();
    #1;
    check("rst_gnt", src_gnt, 0);
    check("rst_credits", credits, 0);
    check("rst_put", put, 0);
    check("rst_err", err, 0);
    check("rst_ptr", dbg_ptr, 0);
    check("rst_state", dbg_state, 0);
    check("rst_din", din, 0);

    // Replenish with requests pending: grant suppressed this cycle
    rst = 1'b0;
    step();
    #1;
    check("init_gnt", src_gnt, 0);
    check("init_busy", busy, 1);
    replenish = 1'b1;
    #1;
    check("repl_gnt", src_gnt, 0);
    step();
    replenish = 1'b0;
    check("repl_credits", credits, 8);
    check("repl_state", dbg_state, 1);

    // Round-robin: 8 grants 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_gnt", src_gnt, 32'(4'b0001 << (k % 4)));
      step();
      check("rr_put", put, 1);
      check("rr_din", din, dat[k % 4]);
      check("rr_credits", credits, 7 - k);
    end
    #1;
    check("empty_gnt", src_gnt, 0);
    check("empty_busy", busy, 1);
    check("empty_ptr", dbg_ptr, 0);
    step();
    check("empty_put", put, 0);
    check("empty_din_hold", din, dat[3]);

    // Steady state: only requester 2, credit_ret every cycle
    src_req = 4'b0100;
    credit_ret = 1'b1;
    #1;
    check("ss_first_gnt", src_gnt, 0);
    step();
    check("ss_credits1", credits, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ss_gnt", src_gnt, 32'h4);
      step();
      check("ss_credits", credits, 1);
      check("ss_put", put, 1);
      check("ss_din", din, dat[2]);
    end
    check("ss_ptr", dbg_ptr, 3);

    // Replenish with simultaneous credit_ret: credit_ret ignored, no overflow
    src_req = 4'b0000;
    replenish = 1'b1;
    step();
    replenish = 1'b0;
    check("ovf_repl_credits", credits, 8);
    check("ovf_repl_err", err, 0);
    // credit_ret at full: overflow
    step();
    credit_ret = 1'b0;
    check("ovf_credits", credits, 8);
    check("ovf_err", err, 1);
    step();
    step();
    check("ovf_err_sticky", err, 1);

    // Grants 3,0,1 bring credits to 5
    src_req = 4'b1111;
    #1;
    check("fl_gnt_a", src_gnt, 32'h8);
    step();
    #1;
    check("fl_gnt_b", src_gnt, 32'h1);
    step();
    #1;
    check("fl_gnt_c", src_gnt, 32'h2);
    step();
    check("fl_credits5", credits, 5);
    check("fl_ptr", dbg_ptr, 2);

    // Flush: no grant this cycle or after
    flush = 1'b1;
    #1;
    check("flush_gnt", src_gnt, 0);
    step();
    flush = 1'b0;
    check("flush_state", dbg_state, 2);
    check("flush_credits", credits, 5);
    check("flush_put", put, 0);
    credit_ret = 1'b1;
    #1;
    check("drain_gnt", src_gnt, 0);
    check("drain_busy", busy, 1);
    step();
    credit_ret = 1'b0;
    check("drain_credits", credits, 6);
    #1;
    check("drain_gnt2", src_gnt, 0);

    // Replenish resumes from saved pointer (2)
    replenish = 1'b1;
    #1;
    check("drepl_gnt", src_gnt, 0);
    step();
    replenish = 1'b0;
    check("drepl_credits", credits, 8);
    check("drepl_state", dbg_state, 1);
    #1;
    check("resume_gnt", src_gnt, 32'h4);
    step();
    check("resume_din", din, dat[2]);
    check("resume_credits", credits, 7);

    // Simultaneous flush + replenish: replenish wins
    flush = 1'b1;
    replenish = 1'b1;
    #1;
    check("fr_gnt", src_gnt, 0);
    step();
    flush = 1'b0;
    replenish = 1'b0;
    check("fr_state", dbg_state, 1);
    check("fr_credits", credits, 8);
    #1;
    check("fr_next_gnt", src_gnt, 32'h8);
    step();
    check("fr_credits7", credits, 7);

    // Grants 0,1,2,3 bring credits to 3 with put in flight
    for (int k = 0; k < 4; k++) begin
      #1;
      check("pre_rst_gnt", src_gnt, 32'(4'b0001 << k));
      step();
    end
    check("pre_rst_credits", credits, 3);
    check("pre_rst_put", put, 1);
    check("pre_rst_err", err, 1);

    // Reset mid-operation
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_put", put, 0);
    check("mrst_credits", credits, 0);
    check("mrst_ptr", dbg_ptr, 0);
    check("mrst_err", err, 0);
    check("mrst_state", dbg_state, 0);
    check("mrst_din", din, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mrst_no_gnt", src_gnt, 0);
      step();
      check("mrst_no_put", put, 0);
    end

    // New replenish: first grant goes to requester 0
    replenish = 1'b1;
    step();
    replenish = 1'b0;
    #1;
    check("final_gnt", src_gnt, 32'h1);
    step();
    check("final_din", din, dat[0]);
    check("final_credits", credits, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
